bpsk_symbol_sequencer: RTL and testbench

- Serialises bytes from a valid/ready stream into BPSK symbols by driving the `modulator` phase-select input of the BPSK modulator datapath.
- Bit changes happen only on carrier zero-crossing pulses, so phase flips never land mid-period.
- Each bit is held for a programmable number of carrier periods.
- A one-deep holding register allows gap-free back-to-back bytes.
- Sits between the Nios-facing TX byte interface and the waveform/BPSK datapath.

---
 rtl/bpsk_symbol_sequencer.sv | 165 ++++++++++++++++
 tb/tb_bpsk_symbol_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_symbol_sequencer.sv
// Byte-to-BPSK symbol sequencer: shifts bytes out MSB first, changing phase only on carrier wraps.
// Optional burst preamble is enabled by defining BPSK_PREAMBLE_EN.
module bpsk_symbol_sequencer #(
  parameter int          PPB_W    = 8,
  parameter logic [7:0]  PREAMBLE = 8'hAA
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [PPB_W-1:0] periods_per_bit,
  input  logic             carrier_wrap,
  output logic             modulator,
  output logic             bit_strobe,
  output logic             byte_done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ALIGN, SEND} state_t;

  state_t           state_q, state_d;
  logic             hold_valid_q, hold_valid_d;
  logic [7:0]       hold_byte_q, hold_byte_d;
  logic [7:0]       shift_reg_q, shift_reg_d;
  logic [PPB_W-1:0] ppb_lat_q, ppb_lat_d;
  logic [PPB_W-1:0] period_cnt_q, period_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             modulator_q, modulator_d;
  logic             bit_strobe_q, bit_strobe_d;
  logic             byte_done_q, byte_done_d;
  logic             busy_q, busy_d;
  logic [PPB_W-1:0] ppb_eff;
  logic             accept;
`ifdef BPSK_PREAMBLE_EN
  logic             pre_q, pre_d;
`endif

  assign ppb_eff    = (periods_per_bit == '0) ? PPB_W'(1) : periods_per_bit;
  assign data_ready = !hold_valid_q;
  assign accept     = data_valid && !hold_valid_q;
  assign modulator  = modulator_q;
  assign bit_strobe = bit_strobe_q;
  assign byte_done  = byte_done_q;
  assign busy       = busy_q;

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_byte_d  = hold_byte_q;
    shift_reg_d  = shift_reg_q;
    ppb_lat_d    = ppb_lat_q;
    period_cnt_d = period_cnt_q;
    bit_idx_d    = bit_idx_q;
    modulator_d  = modulator_q;
    bit_strobe_d = 1'b0;
    byte_done_d  = 1'b0;
`ifdef BPSK_PREAMBLE_EN
    pre_d        = pre_q;
`endif
    case (state_q)
      IDLE: begin
        modulator_d = 1'b1;
        if (hold_valid_q) begin
`ifdef BPSK_PREAMBLE_EN
          // Held data byte stays put; it follows the preamble via the back-to-back path.
          shift_reg_d  = PREAMBLE;
          pre_d        = 1'b1;
`else
          shift_reg_d  = hold_byte_q;
          hold_valid_d = 1'b0;
`endif
          ppb_lat_d = ppb_eff;
          state_d   = ALIGN;
        end
      end
      ALIGN: begin
        if (carrier_wrap) begin
          modulator_d  = shift_reg_q[7];
          bit_idx_d    = 3'd0;
          period_cnt_d = '0;
          bit_strobe_d = 1'b1;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (carrier_wrap) begin
          if (period_cnt_q != ppb_lat_q - PPB_W'(1)) begin
            period_cnt_d = period_cnt_q + PPB_W'(1);
          end else if (bit_idx_q != 3'd7) begin
            bit_idx_d    = bit_idx_q + 3'd1;
            shift_reg_d  = shift_reg_q << 1;
            modulator_d  = shift_reg_q[6];
            period_cnt_d = '0;
            bit_strobe_d = 1'b1;
          end else begin
`ifdef BPSK_PREAMBLE_EN
            byte_done_d = !pre_q;
`else
            byte_done_d = 1'b1;
`endif
            if (hold_valid_q) begin
              shift_reg_d  = hold_byte_q;
              modulator_d  = hold_byte_q[7];
              ppb_lat_d    = ppb_eff;
              period_cnt_d = '0;
              bit_idx_d    = 3'd0;
              bit_strobe_d = 1'b1;
              hold_valid_d = 1'b0;
`ifdef BPSK_PREAMBLE_EN
              pre_d        = 1'b0;
`endif
            end else begin
              modulator_d = 1'b1;
              state_d     = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      hold_byte_d  = data_in;
      hold_valid_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      ppb_lat_q    <= PPB_W'(1);
      period_cnt_q <= '0;
      bit_idx_q    <= 3'd0;
      modulator_q  <= 1'b1;
      bit_strobe_q <= 1'b0;
      byte_done_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef BPSK_PREAMBLE_EN
      pre_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      ppb_lat_q    <= ppb_lat_d;
      period_cnt_q <= period_cnt_d;
      bit_idx_q    <= bit_idx_d;
      modulator_q  <= modulator_d;
      bit_strobe_q <= bit_strobe_d;
      byte_done_q  <= byte_done_d;
      busy_q       <= busy_d;
`ifdef BPSK_PREAMBLE_EN
      pre_q        <= pre_d;
`endif
    end
  end

  // Byte storage is qualified by hold_valid/state, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_byte_q <= hold_byte_d;
    shift_reg_q <= shift_reg_d;
  end

endmodule

// File: tb/tb_bpsk_symbol_sequencer.sv
// Directed bench for bpsk_symbol_sequencer: logs modulator after every carrier wrap and compares
// against hand-written bit patterns.
module tb_bpsk_symbol_sequencer;
  localparam int PPB_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [7:0]       data_in;
  logic             data_valid;
  logic             data_ready;
  logic [PPB_W-1:0] ppb;
  logic             carrier_wrap;
  logic             modulator;
  logic             bit_strobe;
  logic             byte_done;
  logic             busy;

  bpsk_symbol_sequencer #(.PPB_W(PPB_W), .PREAMBLE(8'hAA)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .periods_per_bit(ppb), .carrier_wrap(carrier_wrap),
    .modulator(modulator), .bit_strobe(bit_strobe), .byte_done(byte_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  bit wrap_pend = 1'b0;
  logic mod_log[$];
  logic exp_q[$];

  // Record modulator once after every edge that consumed a carrier_wrap.
  always @(negedge clk) begin
    if (wrap_pend) mod_log.push_back(modulator);
    wrap_pend = carrier_wrap && reset_n;
    if (bit_strobe) strobe_cnt++;
    if (byte_done) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wraps(input int n, input int gap);
    repeat (n) begin
      repeat (gap - 1) tick();
      carrier_wrap = 1'b1;
      tick();
      carrier_wrap = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int waited;
    waited = 0;
    data_in = b;
    data_valid = 1'b1;
    while (!data_ready && waited < 200) begin
      tick();
      waited++;
    end
    check("accept_in_time", (waited < 200), 1);
    tick();
    data_valid = 1'b0;
  endtask

  task automatic push_bits(input logic [7:0] b, input int rep);
    for (int i = 7; i >= 0; i--) repeat (rep) exp_q.push_back(b[i]);
  endtask

  task automatic check_log(input string nm, input int base);
    check({nm, "_len"}, mod_log.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < mod_log.size())
        check($sformatf("%s_wrap%0d", nm, i + 1), mod_log[base + i], exp_q[i]);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] ppb;
    int         gap;
    logic [7:0] exp_bits;
    int         exp_rep;
  } vec_t;

  vec_t vecs[4];
  int base, s0, d0;

  initial begin
    reset_n = 1'b0;
    data_in = 8'h00;
    data_valid = 1'b0;
    carrier_wrap = 1'b0;
    ppb = 8'd2;
    repeat (3) tick();
    check("rst_modulator", modulator, 1);
    check("rst_data_ready", data_ready, 1);
    check("rst_bit_strobe", bit_strobe, 0);
    check("rst_byte_done", byte_done, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    tick();

`ifdef BPSK_PREAMBLE_EN
    ppb = 8'd1;
    base = mod_log.size(); s0 = strobe_cnt; d0 = done_cnt;
    send(8'h3C);
    check("pre_ready_during_burst", data_ready, 0);
    wraps(17, 3);
    tick(); tick();
    exp_q.delete();
    push_bits(8'b1010_1010, 1);
    push_bits(8'b0011_1100, 1);
    exp_q.push_back(1'b1);
    check_log("pre", base);
    check("pre_strobes", strobe_cnt - s0, 16);
    check("pre_byte_done", done_cnt - d0, 1);
    check("pre_busy_end", busy, 0);
`else
    vecs[0] = '{8'hA5, 8'd2, 10, 8'b1010_0101, 2};
    vecs[1] = '{8'h3C, 8'd0, 3,  8'b0011_1100, 1};
    vecs[2] = '{8'h01, 8'd3, 3,  8'b0000_0001, 3};
    vecs[3] = '{8'h80, 8'd1, 5,  8'b1000_0000, 1};
    for (int v = 0; v < 4; v++) begin
      ppb = vecs[v].ppb;
      base = mod_log.size(); s0 = strobe_cnt; d0 = done_cnt;
      send(vecs[v].data);
      wraps(8 * vecs[v].exp_rep + 1, vecs[v].gap);
      tick(); tick();
      exp_q.delete();
      push_bits(vecs[v].exp_bits, vecs[v].exp_rep);
      exp_q.push_back(1'b1);
      check_log($sformatf("vec%0d", v), base);
      check($sformatf("vec%0d_strobes", v), strobe_cnt - s0, 8);
      check($sformatf("vec%0d_byte_done", v), done_cnt - d0, 1);
      check($sformatf("vec%0d_busy_end", v), busy, 0);
      check($sformatf("vec%0d_mod_end", v), modulator, 1);
      check($sformatf("vec%0d_ready_end", v), data_ready, 1);
    end

    // periods_per_bit changes mid-byte: current byte keeps 1 wrap per bit
    ppb = 8'd0;
    base = mod_log.size();
    send(8'hC3);
    wraps(3, 3);
    ppb = 8'd5;
    wraps(6, 3);
    tick(); tick();
    exp_q.delete();
    push_bits(8'hC3, 1);
    exp_q.push_back(1'b1);
    check_log("ppbchg", base);
    check("ppbchg_busy_end", busy, 0);

    // back-to-back FF then 00
    ppb = 8'd1;
    base = mod_log.size(); s0 = strobe_cnt; d0 = done_cnt;
    send(8'hFF);
    send(8'h00);
    check("b2b_ready_held", data_ready, 0);
    check("b2b_busy", busy, 1);
    wraps(17, 4);
    tick(); tick();
    exp_q.delete();
    push_bits(8'hFF, 1);
    push_bits(8'h00, 1);
    exp_q.push_back(1'b1);
    check_log("b2b", base);
    check("b2b_strobes", strobe_cnt - s0, 16);
    check("b2b_byte_done", done_cnt - d0, 2);

    // holding register full with data_valid held high
    base = mod_log.size(); d0 = done_cnt;
    send(8'h81);
    send(8'h7E);
    data_in = 8'h55;
    data_valid = 1'b1;
    repeat (5) tick();
    check("full_ready_low", data_ready, 0);
    wraps(9, 4);
    tick();
    data_valid = 1'b0;
    check("full_third_held", data_ready, 0);
    wraps(16, 4);
    tick(); tick();
    exp_q.delete();
    push_bits(8'h81, 1);
    push_bits(8'h7E, 1);
    push_bits(8'h55, 1);
    exp_q.push_back(1'b1);
    check_log("full", base);
    check("full_byte_done", done_cnt - d0, 3);

    // wrap coincident with the IDLE->ALIGN load edge is ignored
    data_in = 8'h00;
    data_valid = 1'b1;
    s0 = strobe_cnt;
    tick();
    data_valid = 1'b0;
    carrier_wrap = 1'b1;
    tick();
    carrier_wrap = 1'b0;
    tick();
    check("loadwrap_mod", modulator, 1);
    check("loadwrap_strobe", strobe_cnt - s0, 0);
    check("loadwrap_busy", busy, 1);
    base = mod_log.size();
    wraps(9, 3);
    tick(); tick();
    exp_q.delete();
    push_bits(8'h00, 1);
    exp_q.push_back(1'b1);
    check_log("loadwrap", base);

    // asynchronous reset mid-byte with a byte held
    send(8'h00);
    send(8'h00);
    wraps(4, 4);
    check("rstmid_mod_before", modulator, 0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("rstmid_mod", modulator, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_ready", data_ready, 1);
    tick();
    reset_n = 1'b1;
    base = mod_log.size(); s0 = strobe_cnt; d0 = done_cnt;
    wraps(20, 4);
    tick(); tick();
    exp_q.delete();
    repeat (20) exp_q.push_back(1'b1);
    check_log("rstmid_after", base);
    check("rstmid_strobes", strobe_cnt - s0, 0);
    check("rstmid_byte_done", done_cnt - d0, 0);
    check("rstmid_busy_after", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
